fetch_align_buffer: RTL and testbench
=====================================

Name: fetch_align_buffer

Overview:
- Sits directly upstream of the branch predictor and decode, between the instruction cache response and the fetch outputs (instruction, is_comp, pc/pc2/pc4, fetch_valid).
- Accepts 32-bit word-aligned fetch responses and buffers them as halfwords.
- Reassembles RV32IMC instructions, including 32-bit instructions split across two words.
- Emits at most one aligned instruction per cycle with its PC and fall-through addresses; flushes on redirect.

Parameters:
- DEPTH, 4, halfword buffer entries; power of two, minimum 4.
- RESET_PC, 32'h4000_0000, PC loaded into the internal PC register on reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  redirect (mispredict, trap, or taken prediction); highest priority
- flush_pc_i  in  32  new PC on flush; bit 0 ignored
- mem_valid_i  in  1  cache response valid
- mem_ready_o  out  1  buffer can accept a word
- mem_addr_i  in  32  word address of the response; bits [1:0] ignored
- mem_data_i  in  32  response data, little-endian halfwords
- stall_i  in  1  downstream stall; output is held while asserted
- fetch_valid_o  out  1  inst_o is a complete instruction
- inst_o  out  32  instruction; upper 16 bits are zero when compressed
- is_comp_o  out  1  inst_o[1:0] != 2'b11
- pc_o  out  32  PC of inst_o
- pc2_o  out  32  pc_o + 2
- pc4_o  out  32  pc_o + 4
- exp_addr_o  out  32  next word address the buffer expects, for the fetch requester

Behaviour:
- Reset (asynchronous, rst_ni low):
  - occupancy = 0, head/tail pointers = 0, pc_q = RESET_PC, exp_word_q = RESET_PC[31:2], drop_lo_q = RESET_PC[1].
  - Outputs: fetch_valid_o = 0, inst_o = 0, is_comp_o = 0, mem_ready_o = 0 while in reset.
  - Reset mid-operation discards all buffered data.
- Storage:
  - Circular halfword FIFO of DEPTH entries plus a free count.
  - Pointers wrap modulo DEPTH.
- Accept rule:
  - mem_ready_o = (free >= 2) || flush_i.
  - A response is consumed when mem_valid_i && mem_ready_o.
- Stale filter:
  - A consumed word is written only if mem_addr_i[31:2] == exp_word_q and flush_i = 0.
  - Otherwise it is drained silently.
- Write:
  - Push the low halfword, then the high halfword.
  - If drop_lo_q = 1, push only the high halfword and clear drop_lo_q.
  - exp_word_q increments by 1 with 30-bit wrap.
- Head decode (combinational from registered buffer contents):
  - If count >= 1 and head[1:0] != 2'b11: compressed; inst_o = {16'h0, head}; fetch_valid_o = 1.
  - If head[1:0] == 2'b11 and count >= 2: inst_o = {next, head}; fetch_valid_o = 1.
  - If head[1:0] == 2'b11 and count == 1: fetch_valid_o = 0; wait for the next word (split instruction).
- Latency: a word written at edge N is visible on the outputs in cycle N+1. There is no same-cycle bypass.
- Pop:
  - Pop occurs when fetch_valid_o && !stall_i && !flush_i.
  - Pops 1 halfword (compressed) or 2 halfwords.
  - pc_q advances by 2 or 4, with modulo-2^32 wrap.
  - Push and pop in the same cycle are both applied; count = count + pushed - popped.
- Throughput: one instruction per cycle while data is sustained.
- stall_i:
  - Outputs are held stable.
  - Writes continue while free >= 2.
- flush_i (dominates everything in the same cycle):
  - Count, head and tail are cleared.
  - pc_q = {flush_pc_i[31:1], 1'b0}; exp_word_q = flush_pc_i[31:2]; drop_lo_q = flush_pc_i[1].
  - Any write in the flush cycle is discarded.
  - fetch_valid_o = 0 in the following cycle.
- Output derivation: pc2_o and pc4_o are derived combinationally from pc_q.
- Full buffer: mem_ready_o = 0 when free < 2; backpressure reaches the cache.
- Empty buffer: fetch_valid_o = 0. inst_o, pc_o and is_comp_o are don't-care but must not be X in simulation.

Decomposition:
- Shared package (tcore_param):
  - FAB_DEPTH constant.
  - RESET_PC constant.
  - Halfword typedef (logic [15:0]).
  - Helper function is_compressed(halfword).
- Natural sub-module: fab_hw_fifo, the halfword circular buffer. Interface: push 0/1/2, pop 0/1/2, count output, peek of the head and head+1 entries.
- Alignment and PC logic stay in fetch_align_buffer.

Test Plan:
- Reset, then one word at 0x4000_0000 with data 0x0001_4501 (two compressed instructions) -> next cycle: inst 0x0000_4501, pc 0x4000_0000, is_comp 1. Following cycle: inst 0x0000_0001, pc 0x4000_0002, pc2 0x4000_0004.
- Split 32-bit instruction:
  - Stimulus: word 0x4000_0000 = 0x0093_4501, then word 0x4000_0004 = 0x0000_0010.
  - Required: 0x4501 (compressed) is emitted first.
  - fetch_valid_o = 0 while only 0x0093 is held (count 1).
  - Then inst 0x0010_0093 at pc 0x4000_0002, is_comp 0, pc4 0x4000_0006.
- Flush to odd halfword:
  - Stimulus: flush_pc_i = 0x4000_0102, then word 0x4000_0100 = 0xC0DE_BEEF.
  - Required: low halfword 0xBEEF is dropped; first output pc 0x4000_0102 with head halfword 0xC0DE.
- Stale drain: in the cycle after a flush to 0x4000_0200, a response for 0x4000_0010 -> accepted (mem_ready_o = 1), not written, fetch_valid_o stays 0.
- Backpressure: hold stall_i = 1 and stream words -> mem_ready_o falls once free < 2; no data lost; after release, instructions emerge in order, one per cycle.
- Reset mid-operation: assert rst_ni low with 3 halfwords buffered and stall_i = 1 -> fetch_valid_o drops immediately (asynchronously); after release, pc_o = RESET_PC and count = 0.

Source files
------------

// File: rtl/tcore_param.sv
// Shared fetch-side constants, the halfword type and RVC length detection.
package tcore_param;

  localparam int unsigned FAB_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h4000_0000;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_ONE  = 2'd1,
    HW_TWO  = 2'd2
  } hw_cnt_e;

  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_fifo.sv
// Halfword circular buffer: pushes and pops 0..2 entries per cycle and
// exposes the two oldest entries.
module fab_hw_fifo
  import tcore_param::*;
#(
  parameter int unsigned DEPTH = FAB_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic [1:0]             push_n_i,
  input  logic [15:0]            push_d0_i,
  input  logic [15:0]            push_d1_i,
  input  logic [1:0]             pop_n_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [15:0]            peek0_o,
  output logic [15:0]            peek1_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  halfword_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_tail1;

  assign w_head1 = r_head + PW'(1);
  assign w_tail1 = r_tail + PW'(1);

  // Storage is reset so the peeks of an empty buffer are never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push_n_i != 2'd0) r_mem[r_tail] <= push_d0_i;
      if (push_n_i == 2'd2) r_mem[w_tail1] <= push_d1_i;
      r_tail  <= r_tail + PW'(push_n_i);
      r_head  <= r_head + PW'(pop_n_i);
      r_count <= r_count + (PW+1)'(push_n_i) - (PW+1)'(pop_n_i);
    end
  end

  assign count_o = r_count;
  assign peek0_o = r_mem[r_head];
  assign peek1_o = r_mem[w_head1];

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch alignment buffer: turns word-aligned cache responses into one
// aligned RV32IMC instruction per cycle with its PC and fall-through PCs.
module fetch_align_buffer
  import tcore_param::*;
#(
  parameter int unsigned DEPTH    = tcore_param::FAB_DEPTH,
  parameter logic [31:0] RESET_PC = tcore_param::RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        stall_i,
  output logic        fetch_valid_o,
  output logic [31:0] inst_o,
  output logic        is_comp_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc2_o,
  output logic [31:0] pc4_o,
  output logic [31:0] exp_addr_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0] r_pc;
  logic [29:0] r_exp_word;
  logic        r_drop_lo;

  logic [PW:0] w_count;
  logic [PW:0] w_free;
  halfword_t   w_head;
  halfword_t   w_next;
  halfword_t   w_d0;
  logic        w_head_comp;
  logic        w_valid;
  logic        w_accept;
  logic        w_write;
  logic        w_pop;
  hw_cnt_e     w_push_n;
  hw_cnt_e     w_pop_n;
  logic        w_unused_bits;

  assign w_unused_bits = ^{mem_addr_i[1:0], flush_pc_i[0]};

  assign w_free      = (PW+1)'(DEPTH) - w_count;
  assign mem_ready_o = rst_ni && ((w_free >= (PW+1)'(2)) || flush_i);

  assign w_head_comp = is_compressed(w_head);
  assign w_valid     = (w_count != '0) && (w_head_comp || (w_count >= (PW+1)'(2)));
  assign w_accept    = mem_valid_i && mem_ready_o;
  // Words whose address does not match the expected stream are consumed but dropped.
  assign w_write     = w_accept && !flush_i && (mem_addr_i[31:2] == r_exp_word);
  assign w_pop       = w_valid && !stall_i && !flush_i;

  always_comb begin
    w_push_n = HW_NONE;
    w_d0     = mem_data_i[15:0];
    if (w_write) begin
      if (r_drop_lo) begin
        w_push_n = HW_ONE;
        w_d0     = mem_data_i[31:16];
      end else begin
        w_push_n = HW_TWO;
      end
    end
    w_pop_n = HW_NONE;
    if (w_pop) w_pop_n = w_head_comp ? HW_ONE : HW_TWO;
  end

  fab_hw_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .push_n_i (w_push_n),
    .push_d0_i(w_d0),
    .push_d1_i(mem_data_i[31:16]),
    .pop_n_i  (w_pop_n),
    .count_o  (w_count),
    .peek0_o  (w_head),
    .peek1_o  (w_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc       <= RESET_PC;
      r_exp_word <= RESET_PC[31:2];
      r_drop_lo  <= RESET_PC[1];
    end else if (flush_i) begin
      r_pc       <= {flush_pc_i[31:1], 1'b0};
      r_exp_word <= flush_pc_i[31:2];
      r_drop_lo  <= flush_pc_i[1];
    end else begin
      if (w_pop) r_pc <= r_pc + (w_head_comp ? 32'd2 : 32'd4);
      if (w_write) begin
        r_exp_word <= r_exp_word + 30'd1;
        r_drop_lo  <= 1'b0;
      end
    end
  end

  assign fetch_valid_o = w_valid;
  assign is_comp_o     = w_valid && w_head_comp;
  assign inst_o        = !w_valid   ? '0 :
                         w_head_comp ? {16'h0000, w_head} : {w_next, w_head};
  assign pc_o          = r_pc;
  assign pc2_o         = r_pc + 32'd2;
  assign pc4_o         = r_pc + 32'd4;
  assign exp_addr_o    = {r_exp_word, 2'b00};

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// halfword-queue reference model of the fetch alignment buffer.
module tb_fetch_align_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        stall_i = 1'b0;
  logic        fetch_valid_o;
  logic [31:0] inst_o;
  logic        is_comp_o;
  logic [31:0] pc_o;
  logic [31:0] pc2_o;
  logic [31:0] pc4_o;
  logic [31:0] exp_addr_o;

  fetch_align_buffer #(
    .DEPTH   (DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .mem_valid_i  (mem_valid_i),
    .mem_ready_o  (mem_ready_o),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .stall_i      (stall_i),
    .fetch_valid_o(fetch_valid_o),
    .inst_o       (inst_o),
    .is_comp_o    (is_comp_o),
    .pc_o         (pc_o),
    .pc2_o        (pc2_o),
    .pc4_o        (pc4_o),
    .exp_addr_o   (exp_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_q[$];
  logic [31:0] m_pc;
  logic [29:0] m_exp;
  logic        m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    if (m_q.size() == 0) return 1'b0;
    return (m_q[0][1:0] != 2'b11) || (m_q.size() >= 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = RPC;
    m_exp  = 30'(RPC >> 2);
    m_drop = 1'((RPC >> 1) & 32'd1);
  endtask

  task automatic check_outputs();
    bit          v;
    bit          c;
    logic [31:0] ei;
    v = m_valid();
    chk("valid", 32'(fetch_valid_o), 32'(v));
    if (v) begin
      c  = m_q[0][1:0] != 2'b11;
      ei = c ? {16'h0000, m_q[0]} : {m_q[1], m_q[0]};
      chk("is_comp", 32'(is_comp_o), 32'(c));
      chk("inst", inst_o, ei);
    end else begin
      chk("inst_known", 32'($isunknown(inst_o)), 32'd0);
    end
    chk("pc", pc_o, m_pc);
    chk("pc2", pc2_o, m_pc + 32'd2);
    chk("pc4", pc4_o, m_pc + 32'd4);
    chk("exp_addr", exp_addr_o, {m_exp, 2'b00});
  endtask

  task automatic model_step(input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic f, input logic [31:0] fp, input logic s,
                            input bit rdy);
    if (f) begin
      m_q.delete();
      m_pc   = {fp[31:1], 1'b0};
      m_exp  = fp[31:2];
      m_drop = fp[1];
    end else begin
      if (m_valid() && !s) begin
        if (m_q[0][1:0] != 2'b11) begin
          void'(m_q.pop_front());
          m_pc += 32'd2;
        end else begin
          void'(m_q.pop_front());
          void'(m_q.pop_front());
          m_pc += 32'd4;
        end
      end
      if (v && rdy && a[31:2] == m_exp) begin
        if (m_drop) begin
          m_q.push_back(d[31:16]);
          m_drop = 1'b0;
        end else begin
          m_q.push_back(d[15:0]);
          m_q.push_back(d[31:16]);
        end
        m_exp += 30'd1;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic f, input logic [31:0] fp, input logic s);
    bit rdy;
    check_outputs();
    mem_valid_i = v;
    mem_addr_i  = a;
    mem_data_i  = d;
    flush_i     = f;
    flush_pc_i  = fp;
    stall_i     = s;
    #1;
    rdy = ((int'(DEPTH) - m_q.size()) >= 2) || f;
    chk("ready", 32'(mem_ready_o), 32'(rdy));
    @(posedge clk_i);
    model_step(v, a, d, f, fp, s, rdy);
    @(negedge clk_i);
  endtask

  task automatic idle(input logic s);
    cycle(1'b0, '0, '0, 1'b0, '0, s);
  endtask

  task automatic word(input logic [31:0] a, input logic [31:0] d, input logic s);
    cycle(1'b1, a, d, 1'b0, '0, s);
  endtask

  task automatic flush(input logic [31:0] fp, input logic s);
    cycle(1'b0, '0, '0, 1'b1, fp, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset state and two compressed instructions in one word
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'h4000_0000);
    chk("rst_inst", inst_o, 32'h0);
    word(32'h4000_0000, 32'h0001_4501, 1'b0);
    chk("t1_inst0", inst_o, 32'h0000_4501);
    chk("t1_pc0", pc_o, 32'h4000_0000);
    chk("t1_comp0", 32'(is_comp_o), 32'd1);
    idle(1'b0);
    chk("t1_inst1", inst_o, 32'h0000_0001);
    chk("t1_pc1", pc_o, 32'h4000_0002);
    chk("t1_pc2", pc2_o, 32'h4000_0004);
    idle(1'b0);

    // 32-bit instruction split across two words
    flush(32'h4000_0000, 1'b0);
    word(32'h4000_0000, 32'h0093_4501, 1'b0);
    chk("split_c", inst_o, 32'h0000_4501);
    idle(1'b0);
    chk("split_wait", 32'(fetch_valid_o), 32'd0);
    word(32'h4000_0004, 32'h0000_0010, 1'b0);
    chk("split_inst", inst_o, 32'h0010_0093);
    chk("split_pc", pc_o, 32'h4000_0002);
    chk("split_comp", 32'(is_comp_o), 32'd0);
    chk("split_pc4", pc4_o, 32'h4000_0006);
    idle(1'b0);
    idle(1'b0);

    // Flush to an odd halfword drops the low half of the first word
    flush(32'h4000_0102, 1'b0);
    word(32'h4000_0100, 32'hC0DE_BEEF, 1'b0);
    chk("odd_pc", pc_o, 32'h4000_0102);
    chk("odd_inst", inst_o, 32'h0000_C0DE);
    idle(1'b0);

    // Stale response after a flush is consumed but not stored
    flush(32'h4000_0200, 1'b0);
    word(32'h4000_0010, 32'h1234_5678, 1'b0);
    chk("stale_valid", 32'(fetch_valid_o), 32'd0);
    chk("stale_exp", exp_addr_o, 32'h4000_0200);

    // Backpressure under stall, then in-order drain
    flush(32'h4000_1000, 1'b1);
    for (int i = 0; i < 6; i++) word({m_exp, 2'b00}, $urandom, 1'b1);
    chk("bp_full_ready", 32'(mem_ready_o), 32'd0);
    for (int i = 0; i < 6; i++) idle(1'b0);

    // Asynchronous reset with three halfwords held under stall
    flush(32'h4000_0302, 1'b1);
    word(32'h4000_0300, 32'hAAAA_2221, 1'b1);
    word(32'h4000_0304, 32'h3333_4445, 1'b1);
    chk("rst_pre_valid", 32'(fetch_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(fetch_valid_o), 32'd0);
    chk("arst_ready", 32'(mem_ready_o), 32'd0);
    chk("arst_inst", inst_o, 32'h0);
    chk("arst_comp", 32'(is_comp_o), 32'd0);
    model_reset();
    mem_valid_i = 1'b0;
    stall_i     = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("arst_pc", pc_o, RPC);
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        f;
      logic [31:0] fp;
      logic        v;
      logic [31:0] a;
      logic        s;
      f  = ($urandom_range(0, 19) == 0);
      fp = 32'h4000_0000 + 32'($urandom_range(0, 63) << 1);
      v  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 4) == 0)
        a = {m_exp + 30'($urandom_range(1, 7)), 2'($urandom_range(0, 3))};
      else
        a = {m_exp, 2'($urandom_range(0, 3))};
      s  = ($urandom_range(0, 3) == 0);
      cycle(v, a, $urandom, f, fp, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
